// File: rtl/fruit_spawner_if.sv
// -----------------------------------------------------------------------------
// fruit_spawner_if
//
// Launch handshake between the fruit spawner and the downstream fruit stage.
// A launch is offered with spawn_valid and is taken on any cycle where
// spawn_valid and spawn_ready are both high. The launch fields are held
// stable for as long as spawn_valid is high.
//
// Signals
//   spawn_valid  spawner -> fruit stage   launch offered
//   spawn_ready  fruit stage -> spawner   offered launch accepted this cycle
//   spawn_x      spawner -> fruit stage   unsigned launch X position
//   spawn_vx     spawner -> fruit stage   two's-complement X velocity
//   spawn_vy     spawner -> fruit stage   two's-complement Y velocity (<0 is up)
//
// Modports
//   master  the spawner (drives valid and the launch fields)
//   slave   the fruit stage (drives ready)
// -----------------------------------------------------------------------------
interface fruit_spawner_if;

  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [9:0] spawn_vx;
  logic [9:0] spawn_vy;

  modport master (
    output spawn_valid,
    output spawn_x,
    output spawn_vx,
    output spawn_vy,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_x,
    input  spawn_vx,
    input  spawn_vy,
    output spawn_ready
  );

endinterface

// File: rtl/fruit_spawner.sv
// -----------------------------------------------------------------------------
// fruit_spawner
//
// Decides when a new fruit is thrown and with which launch parameters.
// A free-running 16-bit Fibonacci LFSR supplies the randomness. While the
// game is enabled, an interval counter paces launches; the interval shrinks
// by 4 frames per fruit cut, down to a floor of MIN_DELAY frames. When the
// interval has elapsed and the fruit stage is not busy, a launch is offered
// on the spawn interface until it is accepted.
//
// Parameters
//   LFSR_SEED   initial LFSR value (0 is replaced by 16'h0001)
//   BASE_DELAY  spawn interval in frames with no fruits cut
//   MIN_DELAY   lower bound on the spawn interval in frames
//
// Ports
//   frame_clk    sole clock, all state changes on its rising edge
//   Reset        synchronous active-high reset
//   enable       game running; spawning only while high
//   fruits_cut   score used to scale difficulty
//   fruit_busy   fruit stage cannot take a new launch yet
//   spawn        launch handshake (master side)
//   spawn_count  number of accepted launches, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fruit_spawner #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned BASE_DELAY = 120,
  parameter int unsigned MIN_DELAY  = 24
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic            enable,
  input  logic [7:0]      fruits_cut,
  input  logic            fruit_busy,
  fruit_spawner_if.master spawn,
  output logic [7:0]      spawn_count
);

  // Interval counter width; BASE_DELAY and MIN_DELAY must fit in it.
  localparam int unsigned CntW = 16;

  localparam logic [CntW-1:0] BaseDelay = CntW'(BASE_DELAY);
  localparam logic [CntW-1:0] MinDelay  = CntW'(MIN_DELAY);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StOffer
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] reload_val;
  logic [CntW-1:0] ramp;
  logic            cnt_zero;
  logic [9:0]      x_q, vx_q, vy_q;
  logic [9:0]      x_new, vx_new, vy_new, vx_mag;
  logic [7:0]      count_q;
  logic            offer;
  logic            xfer;
  logic            load_cnt;
  logic            load_fields;

  assign cnt_zero = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // LFSR next value: shift left, taps 16/14/13/11 (maximal length).
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // ---------------------------------------------------------------------------
  // Interval for the next wait: BASE_DELAY - 4*fruits_cut, floored at
  // MIN_DELAY. Written as a compare before the subtract so nothing wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramp = CntW'({fruits_cut, 2'b00});
    if ((BaseDelay >= MinDelay) && ((BaseDelay - MinDelay) >= ramp)) begin
      reload_val = BaseDelay - ramp;
    end else begin
      reload_val = MinDelay;
    end
  end

  // ---------------------------------------------------------------------------
  // Launch fields derived from the current LFSR value.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_new  = 10'd64 + {1'b0, lfsr_q[8:0]};
    vx_mag = 10'd1 + {8'd0, lfsr_q[10:9]};
    // Fruits launched from the left half fly right, and vice versa.
    vx_new = (x_new < 10'd320) ? vx_mag : -vx_mag;
    vy_new = -(10'd8 + {7'd0, lfsr_q[13:11]});
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Dropping enable wins over everything else while waiting.
        if (!enable) begin
          state_d = StIdle;
        end else if (cnt_zero && !fruit_busy) begin
          state_d = StOffer;
        end
      end
      StOffer: begin
        // An offer is never withdrawn; enable only picks where we go after it.
        if (spawn.spawn_ready) begin
          state_d = enable ? StWait : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    offer       = (state_q == StOffer);
    xfer        = offer && spawn.spawn_ready;
    // Interval is loaded on entry to WAIT, from IDLE or after a transfer.
    load_cnt    = (state_d == StWait) && (state_q != StWait);
    load_fields = (state_q == StWait) && (state_d == StOffer);

    spawn.spawn_valid = offer;
    spawn.spawn_x     = x_q;
    spawn.spawn_vx    = vx_q;
    spawn.spawn_vy    = vy_q;
    spawn_count       = count_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      lfsr_q  <= SeedEff;
      cnt_q   <= '0;
      x_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      count_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;

      if (load_cnt) begin
        cnt_q <= reload_val;
      end else if ((state_q == StWait) && !cnt_zero) begin
        cnt_q <= cnt_q - 1'b1;
      end

      // Fields only change on entry to OFFER, so they are stable while valid
      // and keep their last values otherwise.
      if (load_fields) begin
        x_q  <= x_new;
        vx_q <= vx_new;
        vy_q <= vy_new;
      end

      if (xfer) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fruit_spawner.sv
// -----------------------------------------------------------------------------
// tb_fruit_spawner
//
// Directed bench for fruit_spawner. Inputs are driven and outputs sampled on
// the falling edge of frame_clk. Launch fields are checked against a
// reference LFSR kept by the bench.
// -----------------------------------------------------------------------------
module tb_fruit_spawner;

  localparam logic [15:0] Seed = 16'hACE1;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic [7:0] fruits_cut;
  logic       fruit_busy;
  logic [7:0] spawn_count;
  logic [7:0] spawn_count0;

  fruit_spawner_if sif ();
  fruit_spawner_if sif0 ();

  fruit_spawner #(
    .LFSR_SEED  (Seed),
    .BASE_DELAY (120),
    .MIN_DELAY  (24)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .fruits_cut  (fruits_cut),
    .fruit_busy  (fruit_busy),
    .spawn       (sif),
    .spawn_count (spawn_count)
  );

  // Second instance only exercises the zero-seed substitution.
  fruit_spawner #(
    .LFSR_SEED  (16'h0000),
    .BASE_DELAY (120),
    .MIN_DELAY  (24)
  ) dut0 (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (1'b0),
    .fruits_cut  (8'd0),
    .fruit_busy  (1'b0),
    .spawn       (sif0),
    .spawn_count (spawn_count0)
  );

  assign sif0.spawn_ready = 1'b0;

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  int field_err = 0;
  int range_err = 0;
  int n_launch  = 0;

  // Reference LFSR: m_prev is the value before the most recent edge, i.e. the
  // value the DUT registered its fields from when it entered OFFER.
  logic [15:0] m_lfsr, m_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge frame_clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= Reset ? Seed : lfsr_next(m_lfsr);
  end

  // Watch the zero-seeded LFSR for a lock-up value.
  logic watch_on = 1'b0;
  int   watch_cyc = 0;
  int   zero_hits = 0;

  always @(negedge frame_clk) begin
    if (watch_on) begin
      watch_cyc <= watch_cyc + 1;
      if (dut0.lfsr_q == 16'h0000) zero_hits <= zero_hits + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge frame_clk);
  endtask

  // Steps until spawn_valid is seen; n is the number of falling edges taken.
  task automatic until_valid(output int n);
    n = 0;
    do begin
      @(negedge frame_clk);
      n++;
    end while ((sif.spawn_valid !== 1'b1) && (n < 300));
  endtask

  // Step through the edge on which an offered launch is taken.
  task automatic accept();
    @(negedge frame_clk);
    xfers++;
  endtask

  task automatic check_fields();
    logic [15:0] l;
    logic [9:0]  ex, mag, evx, evy;
    l   = m_prev;
    ex  = 10'd64 + {1'b0, l[8:0]};
    mag = 10'd1 + {8'd0, l[10:9]};
    evx = (ex < 10'd320) ? mag : (~mag + 10'd1);
    evy = ~(10'd8 + {7'd0, l[13:11]}) + 10'd1;
    if ((sif.spawn_x !== ex) || (sif.spawn_vx !== evx) || (sif.spawn_vy !== evy)) field_err++;
    if ((sif.spawn_x < 10'd64) || (sif.spawn_x > 10'd575)) range_err++;
    if (($signed(sif.spawn_vx) > 0) != (sif.spawn_x < 10'd320)) range_err++;
    if (($signed(sif.spawn_vy) < -15) || ($signed(sif.spawn_vy) > -8)) range_err++;
    n_launch++;
  endtask

  initial begin
    int n;
    int bad;
    int timing_err;
    logic [9:0] hx, hvx, hvy;

    Reset      = 1'b1;
    enable     = 1'b0;
    fruits_cut = 8'd0;
    fruit_busy = 1'b0;
    sif.spawn_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_valid", {31'd0, sif.spawn_valid}, 32'd0);
    chk("rst_x", {22'd0, sif.spawn_x}, 32'd0);
    chk("rst_vx", {22'd0, sif.spawn_vx}, 32'd0);
    chk("rst_vy", {22'd0, sif.spawn_vy}, 32'd0);
    chk("rst_count", {24'd0, spawn_count}, 32'd0);
    chk("seed0_lfsr", {16'd0, dut0.lfsr_q}, 32'd1);

    Reset    = 1'b0;
    watch_on = 1'b1;
    step();
    chk("idle_no_valid", {31'd0, sif.spawn_valid}, 32'd0);

    // Basic timing: D=120 -> valid seen D+2 falling edges after enable
    enable = 1'b1;
    until_valid(n);
    chk("first_wait", n, 32'd122);
    check_fields();
    accept();
    chk("valid_one_cycle", {31'd0, sif.spawn_valid}, 32'd0);
    chk("count_one", {24'd0, spawn_count}, 32'd1);
    until_valid(n);
    chk("second_wait", n, 32'd121);
    check_fields();

    // Difficulty: fruits_cut sampled on the transfer edge, wait is D+1
    fruits_cut = 8'd20;  accept(); until_valid(n); chk("fc20_d40", n, 32'd41);  check_fields();
    fruits_cut = 8'd23;  accept(); until_valid(n); chk("fc23_d28", n, 32'd29);  check_fields();
    fruits_cut = 8'd24;  accept(); until_valid(n); chk("fc24_d24", n, 32'd25);  check_fields();
    fruits_cut = 8'd30;  accept(); until_valid(n); chk("fc30_d24", n, 32'd25);  check_fields();
    fruits_cut = 8'd255; accept(); until_valid(n); chk("fc255_d24", n, 32'd25); check_fields();

    // Busy is ignored in OFFER but holds WAIT at counter 0
    fruit_busy = 1'b1;
    accept();
    chk("busy_offer_xfer", {24'd0, spawn_count}, xfers % 256);
    bad = 0;
    for (int i = 0; i < 75; i++) begin
      step();
      if (sif.spawn_valid !== 1'b0) bad++;
    end
    chk("busy_no_valid", bad, 32'd0);
    fruit_busy = 1'b0;
    step();
    chk("busy_release_offer", {31'd0, sif.spawn_valid}, 32'd1);
    check_fields();

    // Ready back-pressure: offer and fields hold
    sif.spawn_ready = 1'b0;
    hx = sif.spawn_x; hvx = sif.spawn_vx; hvy = sif.spawn_vy;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ((sif.spawn_valid !== 1'b1) || (sif.spawn_x !== hx) || (sif.spawn_vx !== hvx) ||
          (sif.spawn_vy !== hvy)) bad++;
    end
    chk("stall_stable", bad, 32'd0);
    sif.spawn_ready = 1'b1;
    accept();
    chk("stall_xfer_valid", {31'd0, sif.spawn_valid}, 32'd0);
    chk("stall_xfer_count", {24'd0, spawn_count}, xfers % 256);

    // Enable drop in WAIT: back to IDLE, re-enable reloads the full interval
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sif.spawn_valid !== 1'b0) bad++;
    end
    chk("wait_drop_no_valid", bad, 32'd0);
    enable = 1'b1;
    until_valid(n);
    chk("wait_drop_reenable", n, 32'd26);
    check_fields();

    // Enable drop in OFFER: offer held, IDLE after acceptance
    sif.spawn_ready = 1'b0;
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (sif.spawn_valid !== 1'b1) bad++;
    end
    chk("offer_drop_held", bad, 32'd0);
    sif.spawn_ready = 1'b1;
    accept();
    chk("offer_drop_count", {24'd0, spawn_count}, xfers % 256);
    enable = 1'b1;
    until_valid(n);
    chk("offer_drop_idle", n, 32'd26);
    check_fields();

    // 1000 launches against the reference LFSR, covering count wrap
    timing_err = 0;
    for (int i = 0; i < 1000; i++) begin
      check_fields();
      accept();
      if (xfers == 256) chk("count_wrap", {24'd0, spawn_count}, 32'd0);
      until_valid(n);
      if (n != 25) timing_err++;
    end
    chk("bulk_timing", timing_err, 32'd0);
    chk("bulk_fields", field_err, 32'd0);
    chk("bulk_ranges", range_err, 32'd0);
    chk("bulk_count", {24'd0, spawn_count}, xfers % 256);

    // Reset in OFFER overrides ready and enable
    Reset = 1'b1;
    sif.spawn_ready = 1'b1;
    step();
    chk("rst_offer_valid", {31'd0, sif.spawn_valid}, 32'd0);
    chk("rst_offer_count", {24'd0, spawn_count}, 32'd0);
    chk("rst_offer_x", {22'd0, sif.spawn_x}, 32'd0);
    chk("rst_offer_vx", {22'd0, sif.spawn_vx}, 32'd0);
    chk("rst_offer_vy", {22'd0, sif.spawn_vy}, 32'd0);
    Reset = 1'b0;
    fruits_cut = 8'd0;
    until_valid(n);
    chk("post_rst_wait", n, 32'd122);
    field_err = 0;
    check_fields();
    chk("post_rst_fields", field_err, 32'd0);

    // Zero-seeded LFSR never reaches 0
    while (watch_cyc < 70000) step();
    chk("seed0_no_zero", zero_hits, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
